// File: rtl/rca16_sched.sv
// rca16_sched: two-requester scheduler for one shared ripple-carry adder.
// A grant latches the winner's operands onto the adder drive. The scheduler
// then waits SETTLE cycles for the carry chain to ripple, captures the result
// and pulses the winner's ack for one cycle. Ties go round-robin.
module rca16_sched #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin0,
  input  logic             cin1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Counter starts at SETTLE-1 so the capture lands exactly SETTLE edges
  // after the grant edge.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t           state_reg;
  logic [3:0]       cnt_reg;
  logic             last_reg;   // requester granted most recently
  logic             sel_reg;    // requester owning the current operation
  logic             ack0_reg;
  logic             ack1_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic [WIDTH-1:0] add_a_reg;
  logic [WIDTH-1:0] add_b_reg;
  logic             add_cin_reg;

  logic grant_any;
  logic grant_sel;

  // Arbitration: a lone request wins outright; a tie goes to the requester
  // that was not served last.
  always_comb begin
    grant_any = req0 | req1;
    grant_sel = (req0 && req1) ? ~last_reg : req1;
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 4'd0;
      last_reg    <= 1'b1;      // pretend 1 went last so 0 wins the first tie
      sel_reg     <= 1'b0;
      ack0_reg    <= 1'b0;
      ack1_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
      add_a_reg   <= '0;
      add_b_reg   <= '0;
      add_cin_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            sel_reg     <= grant_sel;
            last_reg    <= grant_sel;
            add_a_reg   <= grant_sel ? a1 : a0;
            add_b_reg   <= grant_sel ? b1 : b0;
            add_cin_reg <= grant_sel ? cin1 : cin0;
            cnt_reg     <= CNT_INIT;
            busy_reg    <= 1'b1;
            state_reg   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            sum_reg   <= add_sum;
            cout_reg  <= add_cout;
            ack0_reg  <= ~sel_reg;
            ack1_reg  <= sel_reg;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          ack0_reg  <= 1'b0;
          ack1_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          ack0_reg  <= 1'b0;
          ack1_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0     = ack0_reg;
  assign ack1     = ack1_reg;
  assign busy     = busy_reg;
  assign sum_out  = sum_reg;
  assign cout_out = cout_reg;
  assign add_a    = add_a_reg;
  assign add_b    = add_b_reg;
  assign add_cin  = add_cin_reg;

endmodule

// File: doc/rca16_sched.md
RCA16_SCHED -- requirements
Module: rca16_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width.
REQ-002 SHALL have parameter SETTLE, default 4: cycles the shared adder is given to ripple (legal 1..15).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports req0, req1, input, 1 each: add request from requester 0 / 1.
REQ-006 SHALL have ports a0, b0, a1, b1, input, WIDTH each: operands of requester 0 / 1.
REQ-007 SHALL have ports cin0, cin1, input, 1 each: carry-in of requester 0 / 1.
REQ-008 SHALL have ports ack0, ack1, output, 1 each: one-cycle completion pulse to requester 0 / 1.
REQ-009 SHALL have port sum_out, output, WIDTH: registered result of the last completed add.
REQ-010 SHALL have port cout_out, output, 1: registered carry-out of the last completed add.
REQ-011 SHALL have port busy, output, 1: high while not IDLE.
REQ-012 SHALL have ports add_a, add_b, output, WIDTH; add_cin, output, 1: registered drive to the shared ripple-carry adder.
REQ-013 SHALL have ports add_sum, input, WIDTH; add_cout, input, 1: shared adder outputs.

Function
REQ-014 SHALL implement the FSM IDLE -> SETTLE -> DONE -> IDLE.
REQ-015 In IDLE with exactly one reqN high at a rising edge, SHALL grant N, latch aN/bN/cinN into add_a/add_b/add_cin, load the counter with SETTLE-1, and enter SETTLE.
REQ-016 In IDLE with both requests high, SHALL grant the requester not granted most recently (round-robin); the pointer toggles only on a grant.
REQ-017 In IDLE with no request, SHALL hold state and all outputs.
REQ-018 In SETTLE with counter nonzero, SHALL decrement the counter by 1 per cycle, holding add_a/add_b/add_cin stable.
REQ-019 In SETTLE with counter zero, SHALL capture add_sum/add_cout into sum_out/cout_out and enter DONE.
REQ-020 In DONE, SHALL assert ack of the granted requester for exactly one cycle, then return to IDLE.
REQ-021 ack0 and ack1 SHALL never be high in the same cycle; neither SHALL be high outside DONE.
REQ-022 Latency SHALL be exactly SETTLE cycles from the sampling edge of req to the edge at which ack rises; ack high for 1 cycle; minimum req-to-req service period SETTLE+2 cycles.
REQ-023 Requests and operands SHALL be sampled only in IDLE; changes during SETTLE/DONE are ignored.
REQ-024 A req dropped during SETTLE SHALL NOT abort the operation; ack still pulses.
REQ-025 A req still high in the IDLE cycle after DONE SHALL be treated as a new request (new add, new ack).
REQ-026 sum_out/cout_out SHALL hold their value until the next DONE capture.
REQ-027 busy SHALL be high in SETTLE and DONE and low in IDLE.
REQ-028 Carry-out SHALL be the adder's add_cout; no width extension or saturation.

Reset
REQ-029 On rst high, asynchronously: state IDLE, counter 0, round-robin pointer favouring requester 0, ack0/ack1/busy 0, sum_out/add_a/add_b 0, cout_out/add_cin 0.
REQ-030 rst asserted mid-operation SHALL abort it with no ack; first request after release is arbitrated fresh.

Verification
REQ-031 Single add: SETTLE=4, req0=1, a0=16'h00FF, b0=16'h0001, cin0=0 sampled at edge 0 -> ack0 high between edges 4 and 5, sum_out=16'h0100, cout_out=0, ack1 never high.
REQ-032 Overflow: req1=1, a1=16'hFFFF, b1=16'h0000, cin1=1 -> sum_out=16'h0000, cout_out=1, ack1 one pulse.
REQ-033 Contention: req0 and req1 held high from reset release -> grants alternate 0,1,0,1; acks spaced SETTLE+2 cycles; each sum matches its own operands.
REQ-034 Operand hold: change a0 during SETTLE -> add_a unchanged, sum_out reflects operands sampled in IDLE.
REQ-035 Reset mid-op: rst pulsed at SETTLE counter 2 -> no ack, busy=0 and all outputs 0 immediately; subsequent req0 completes normally.
REQ-036 SETTLE=1: req0 sampled at edge 0 -> ack0 high between edges 1 and 2.
